// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the multi-cycle MIPS control path.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAddr  = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StRExec    = 4'd6,
      StRWb      = 4'd7,
      StBranch   = 4'd8,
      StJump     = 4'd9,
      StAddiExec = 4'd10,
      StAddiWb   = 4'd11
   } state_e;

endpackage

// File: rtl/alu_control_decode.sv
// R-type funct field to ALU control code, with a flag for supported functs.
module alu_control_decode
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_control,
   output logic       funct_valid
);

   always_comb begin
      alu_control = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FN_ADD:  alu_control = ALU_ADD;
         FN_SUB:  alu_control = ALU_SUB;
         FN_AND:  alu_control = ALU_AND;
         FN_OR:   alu_control = ALU_OR;
         FN_SLT:  alu_control = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath; also counts retired instructions.
module multicycle_control
   import mips_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic [3:0]       alu_control,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_source,
   output logic             pc_en,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state
);

   state_e           state_q, state_d, out_st;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic [3:0]       r_alu_control;
   logic             funct_valid;
   logic             opcode_legal;
   logic             retire;
   logic             pc_write, pc_write_cond;
   logic             mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

   alu_control_decode u_alu_control_decode (
      .funct       (funct),
      .alu_control (r_alu_control),
      .funct_valid (funct_valid)
   );

   always_comb begin
      opcode_legal = 1'b0;
      case (opcode)
         OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_legal = 1'b1;
         OP_RTYPE:                            opcode_legal = funct_valid;
         default:                             opcode_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = StFetch;
      retire  = 1'b0;
      case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            case (opcode)
               OP_LW, OP_SW: state_d = StMemAddr;
               OP_BEQ:       state_d = StBranch;
               OP_J:         state_d = StJump;
               OP_ADDI:      state_d = StAddiExec;
               OP_RTYPE:     state_d = funct_valid ? StRExec : StFetch;
               default:      state_d = StFetch;
            endcase
         end
         StMemAddr: begin
            if (opcode == OP_LW) begin
               state_d = StMemRead;
            end else if (opcode == OP_SW) begin
               state_d = StMemWrite;
            end else begin
               state_d = StFetch;
            end
         end
         StMemRead:  state_d = StMemWb;
         StRExec:    state_d = StRWb;
         StAddiExec: state_d = StAddiWb;
         StMemWb, StMemWrite, StRWb, StBranch, StJump, StAddiWb: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         default:    state_d = StFetch;
      endcase
   end

   assign instr_count_d = retire ? instr_count_q + CNT_W'(1) : instr_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StFetch;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Under reset, decode as FETCH so the datapath sees a clean idle selection.
   assign out_st = rst_n ? state_q : StFetch;

   always_comb begin
      alu_control   = ALU_ADD;
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_REG;
      pc_source     = PC_SRC_ALU;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      illegal_raw   = 1'b0;
      case (out_st)
         StFetch: begin
            mem_read     = 1'b1;
            ir_write_raw = 1'b1;
            alu_src_b    = SRC_B_FOUR;
            pc_write     = 1'b1;
         end
         StDecode: begin
            alu_src_b   = SRC_B_IMM_SH;
            illegal_raw = !opcode_legal;
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         StMemRead: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         StMemWb: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = 1'b1;
         end
         StMemWrite: begin
            mem_write_raw = 1'b1;
            i_or_d        = 1'b1;
         end
         StRExec: begin
            alu_src_a   = 1'b1;
            alu_control = r_alu_control;
         end
         StRWb: begin
            reg_write_raw = 1'b1;
            reg_dst       = 1'b1;
         end
         StBranch: begin
            alu_src_a     = 1'b1;
            alu_control   = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PC_SRC_ALUOUT;
         end
         StJump: begin
            pc_write  = 1'b1;
            pc_source = PC_SRC_JUMP;
         end
         StAddiExec: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         StAddiWb: reg_write_raw = 1'b1;
         default: ;
      endcase
   end

   assign mem_write   = mem_write_raw & rst_n;
   assign ir_write    = ir_write_raw & rst_n;
   assign reg_write   = reg_write_raw & rst_n;
   assign illegal     = illegal_raw & rst_n;
   assign pc_en       = (pc_write | (pc_write_cond & zero)) & rst_n;
   assign instr_count = instr_count_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (4-bit counter instance).
module tb_multicycle_control;

   logic       clk, rst_n, zero;
   logic [5:0] opcode, funct;
   logic [3:0] alu_control, instr_count, state;
   logic [1:0] alu_src_b, pc_source;
   logic       alu_src_a, pc_en, i_or_d, mem_read, mem_write, ir_write;
   logic       reg_write, reg_dst, mem_to_reg, illegal;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [3:0] exp_cnt = 4'd0;

   multicycle_control #(.CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .alu_control (alu_control),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .pc_source   (pc_source),
      .pc_en       (pc_en),
      .i_or_d      (i_or_d),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_write   (reg_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .illegal     (illegal),
      .instr_count (instr_count),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
      step(); step();
      n_tests++;
      if (state !== 4'd0 || instr_count !== 4'd0) begin
         $display("FAIL reset_state: state=%0d cnt=%0d, expected 0/0", state, instr_count);
         n_fail++;
      end
      n_tests++;
      if ({mem_write, reg_write, ir_write, pc_en, illegal} !== 5'b0 || mem_read !== 1'b1) begin
         $display("FAIL reset_outputs: we/rw/ir/pc/ill=%b mem_read=%b, expected 00000/1",
                  {mem_write, reg_write, ir_write, pc_en, illegal}, mem_read);
         n_fail++;
      end
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (pc_en !== 1'b1 || ir_write !== 1'b1 || alu_control !== 4'b0010 ||
          alu_src_b !== 2'b01 || alu_src_a !== 1'b0) begin
         $display("FAIL fetch_after_reset: pc_en=%b ir=%b alu=%b srcb=%b srca=%b, exp 1 1 0010 01 0",
                  pc_en, ir_write, alu_control, alu_src_b, alu_src_a);
         n_fail++;
      end
   endtask

   task automatic test_lw();
      int seq[5] = '{0, 1, 2, 3, 4};
      opcode = 6'b100011;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (state !== 4'(seq[i]) || reg_write !== (i == 4)) begin
            $display("FAIL lw_seq[%0d]: state=%0d reg_write=%b, expected %0d/%b",
                     i, state, reg_write, seq[i], (i == 4));
            n_fail++;
         end
         if (i == 2) begin
            n_tests++;
            if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_control !== 4'b0010) begin
               $display("FAIL lw_addr: srca=%b srcb=%b alu=%b, expected 1 10 0010",
                        alu_src_a, alu_src_b, alu_control);
               n_fail++;
            end
         end
         if (i == 3) begin
            n_tests++;
            if (mem_read !== 1'b1 || i_or_d !== 1'b1 || mem_write !== 1'b0) begin
               $display("FAIL lw_read: mem_read=%b i_or_d=%b mem_write=%b, expected 1 1 0",
                        mem_read, i_or_d, mem_write);
               n_fail++;
            end
         end
         if (i == 4) begin
            n_tests++;
            if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
               $display("FAIL lw_wb: mem_to_reg=%b reg_dst=%b, expected 1 0", mem_to_reg, reg_dst);
               n_fail++;
            end
         end
         step();
      end
      exp_cnt++;
      n_tests++;
      if (state !== 4'd0 || instr_count !== exp_cnt) begin
         $display("FAIL lw_retire: state=%0d cnt=%0d, expected 0/%0d", state, instr_count, exp_cnt);
         n_fail++;
      end
   endtask

   task automatic test_sw_addi();
      int sw_seq[4]   = '{0, 1, 2, 5};
      int addi_seq[4] = '{0, 1, 10, 11};
      opcode = 6'b101011;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (state !== 4'(sw_seq[i]) || mem_write !== (i == 3) || reg_write !== 1'b0) begin
            $display("FAIL sw_seq[%0d]: state=%0d mem_write=%b reg_write=%b, expected %0d/%b/0",
                     i, state, mem_write, reg_write, sw_seq[i], (i == 3));
            n_fail++;
         end
         step();
      end
      exp_cnt++;
      opcode = 6'b001000;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (state !== 4'(addi_seq[i]) || reg_write !== (i == 3)) begin
            $display("FAIL addi_seq[%0d]: state=%0d reg_write=%b, expected %0d/%b",
                     i, state, reg_write, addi_seq[i], (i == 3));
            n_fail++;
         end
         if (i == 3) begin
            n_tests++;
            if (reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
               $display("FAIL addi_wb: reg_dst=%b mem_to_reg=%b, expected 0 0", reg_dst, mem_to_reg);
               n_fail++;
            end
         end
         step();
      end
      exp_cnt++;
      n_tests++;
      if (state !== 4'd0 || instr_count !== exp_cnt) begin
         $display("FAIL sw_addi_retire: state=%0d cnt=%0d, expected 0/%0d",
                  state, instr_count, exp_cnt);
         n_fail++;
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fns[5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [3:0] alus[5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
      opcode = 6'b000000;
      for (int k = 0; k < 5; k++) begin
         funct = fns[k];
         step();
         n_tests++;
         if (state !== 4'd1 || illegal !== 1'b0) begin
            $display("FAIL rtype_decode[%0d]: state=%0d illegal=%b, expected 1/0", k, state, illegal);
            n_fail++;
         end
         step();
         n_tests++;
         if (state !== 4'd6 || alu_control !== alus[k] || alu_src_a !== 1'b1 ||
             alu_src_b !== 2'b00) begin
            $display("FAIL rtype_exec[%0d]: state=%0d alu=%b srca=%b srcb=%b, expected 6 %b 1 00",
                     k, state, alu_control, alu_src_a, alu_src_b, alus[k]);
            n_fail++;
         end
         step();
         n_tests++;
         if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
            $display("FAIL rtype_wb[%0d]: state=%0d rw=%b dst=%b m2r=%b, expected 7 1 1 0",
                     k, state, reg_write, reg_dst, mem_to_reg);
            n_fail++;
         end
         step();
         exp_cnt++;
      end
      n_tests++;
      if (state !== 4'd0 || instr_count !== exp_cnt) begin
         $display("FAIL rtype_count: state=%0d cnt=%0d, expected 0/%0d", state, instr_count, exp_cnt);
         n_fail++;
      end
   endtask

   task automatic test_beq();
      logic zs[2] = '{1'b1, 1'b0};
      opcode = 6'b000100;
      for (int k = 0; k < 2; k++) begin
         zero = zs[k];
         step();
         n_tests++;
         if (state !== 4'd1 || pc_en !== 1'b0) begin
            $display("FAIL beq_decode[%0d]: state=%0d pc_en=%b, expected 1/0", k, state, pc_en);
            n_fail++;
         end
         step();
         n_tests++;
         if (state !== 4'd8 || pc_en !== zs[k] || pc_source !== 2'b01 || alu_control !== 4'b0110) begin
            $display("FAIL beq_branch[%0d]: state=%0d pc_en=%b pcsrc=%b alu=%b, expected 8 %b 01 0110",
                     k, state, pc_en, pc_source, alu_control, zs[k]);
            n_fail++;
         end
         step();
         exp_cnt++;
         n_tests++;
         if (state !== 4'd0 || instr_count !== exp_cnt) begin
            $display("FAIL beq_retire[%0d]: state=%0d cnt=%0d, expected 0/%0d",
                     k, state, instr_count, exp_cnt);
            n_fail++;
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_illegal();
      logic [5:0] ops[2] = '{6'b111111, 6'b000000};
      logic [5:0] fns[2] = '{6'b000000, 6'b000111};
      for (int k = 0; k < 2; k++) begin
         opcode = ops[k];
         funct  = fns[k];
         n_tests++;
         if (illegal !== 1'b0) begin
            $display("FAIL illegal_fetch[%0d]: illegal=%b, expected 0", k, illegal);
            n_fail++;
         end
         step();
         n_tests++;
         if (state !== 4'd1 || illegal !== 1'b1) begin
            $display("FAIL illegal_decode[%0d]: state=%0d illegal=%b, expected 1/1", k, state, illegal);
            n_fail++;
         end
         step();
         n_tests++;
         if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== exp_cnt) begin
            $display("FAIL illegal_return[%0d]: state=%0d illegal=%b cnt=%0d, expected 0/0/%0d",
                     k, state, illegal, instr_count, exp_cnt);
            n_fail++;
         end
      end
   endtask

   task automatic test_mid_reset();
      opcode = 6'b000000;
      funct  = 6'b100000;
      step(); step();
      n_tests++;
      if (state !== 4'd6) begin
         $display("FAIL midrst_setup: state=%0d, expected 6", state);
         n_fail++;
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({mem_write, reg_write, ir_write, pc_en, illegal} !== 5'b0 || alu_control !== 4'b0010 ||
          alu_src_a !== 1'b0 || mem_read !== 1'b1) begin
         $display("FAIL midrst_comb: we/rw/ir/pc/ill=%b alu=%b srca=%b mr=%b, expected 00000 0010 0 1",
                  {mem_write, reg_write, ir_write, pc_en, illegal}, alu_control, alu_src_a, mem_read);
         n_fail++;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++;
         if (state !== 4'd0 || instr_count !== 4'd0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            $display("FAIL midrst_hold[%0d]: state=%0d cnt=%0d rw=%b mw=%b, expected 0 0 0 0",
                     i, state, instr_count, reg_write, mem_write);
            n_fail++;
         end
      end
      exp_cnt = 4'd0;
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (state !== 4'd0 || pc_en !== 1'b1 || alu_control !== 4'b0010) begin
         $display("FAIL midrst_release: state=%0d pc_en=%b alu=%b, expected 0 1 0010",
                  state, pc_en, alu_control);
         n_fail++;
      end
   endtask

   task automatic test_wrap();
      opcode = 6'b000010;
      for (int k = 0; k < 16; k++) begin
         step();
         n_tests++;
         if (state !== 4'd1) begin
            $display("FAIL j_decode[%0d]: state=%0d, expected 1", k, state);
            n_fail++;
         end
         step();
         n_tests++;
         if (state !== 4'd9 || pc_source !== 2'b10 || pc_en !== 1'b1) begin
            $display("FAIL j_jump[%0d]: state=%0d pcsrc=%b pc_en=%b, expected 9 10 1",
                     k, state, pc_source, pc_en);
            n_fail++;
         end
         step();
         exp_cnt++;
         n_tests++;
         if (state !== 4'd0 || instr_count !== exp_cnt) begin
            $display("FAIL j_count[%0d]: state=%0d cnt=%0d, expected 0/%0d",
                     k, state, instr_count, exp_cnt);
            n_fail++;
         end
      end
      n_tests++;
      if (instr_count !== 4'd0) begin
         $display("FAIL wrap_zero: cnt=%0d, expected 0", instr_count);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_addi();
      test_rtype();
      test_beq();
      test_illegal();
      test_mid_reset();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
